// File: rtl/ifu_iccm_arb_pkg.sv
// Shared types and sizing helpers for the ICCM fetch/DMA port arbiter.
package ifu_iccm_arb_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT     = 3'd1,
    RMW_RD   = 3'd2,
    RMW_HOLD = 3'd3,
    RMW_WR   = 3'd4
  } state_t;

  localparam logic [1:0] SZ_B  = 2'd0;
  localparam logic [1:0] SZ_H  = 2'd1;
  localparam logic [1:0] SZ_W  = 2'd2;
  localparam logic [1:0] SZ_DW = 2'd3;

  // RMW hold counter only has to cover RD_LAT-2 cycles for RD_LAT <= 4
  localparam int HOLD_W = 2;

  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ifu_iccm_rdpipe.sv
// Tracks DMA reads through the ICCM read latency; emits valid+tag RD_LAT cycles after rden.
module ifu_iccm_rdpipe #(
  parameter int RD_LAT = 2,
  parameter int TAG_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_vld,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             out_vld,
  output logic [TAG_W-1:0] out_tag
);

  logic [RD_LAT-1:0][TAG_W:0] pipe_d, pipe_q;

  always_comb begin
    pipe_d    = pipe_q;
    // tag is zeroed on empty slots so the output tag idles at 0
    pipe_d[0] = {rd_vld, rd_tag & {TAG_W{rd_vld}}};
    for (int i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];
  end

  rvdff #(.WIDTH(RD_LAT*(TAG_W+1))) pipe_ff (
    .clk (clk),
    .rst (rst),
    .din (pipe_d),
    .dout(pipe_q)
  );

  assign out_vld = pipe_q[RD_LAT-1][TAG_W];
  assign out_tag = pipe_q[RD_LAT-1][TAG_W-1:0];

endmodule

// File: rtl/rvdff.sv
// Plain synchronous-reset D flop vector used for all state in this slice.
module rvdff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk) begin
    if (rst) dout <= '0;
    else     dout <= din;
  end

endmodule

// File: rtl/ifu_iccm_dma_arb.sv
// Arbitrates the single ICCM port between fetch and DMA: direct grants, starvation-forced
// fetch stall, and read-modify-write sequencing for sub-doubleword DMA writes.
module ifu_iccm_dma_arb
  import ifu_iccm_arb_pkg::*;
#(
  parameter int RD_LAT   = 2,
  parameter int MAX_WAIT = 15,
  parameter int TAG_W    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ifc_dma_access_ok,
  input  logic             dma_iccm_req,
  input  logic             dma_iccm_write,
  input  logic [1:0]       dma_iccm_size,
  input  logic [TAG_W-1:0] dma_iccm_tag,
  output logic             dma_iccm_ready,
  output logic             dma_iccm_stall_any,
  output logic             iccm_sel_dma,
  output logic             iccm_rden,
  output logic             iccm_wren,
  output logic             iccm_rmw_merge,
  output logic             iccm_dma_rvalid,
  output logic [TAG_W-1:0] iccm_dma_rtag
);

  localparam int                 WCNT_W    = cnt_w(MAX_WAIT);
  localparam logic [WCNT_W-1:0]  WCNT_MAX  = WCNT_W'(MAX_WAIT);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = (RD_LAT > 2) ? HOLD_W'(RD_LAT - 3) : '0;

  state_t              state_d, state_q;
  logic [2:0]          state_raw;
  logic [WCNT_W-1:0]   wait_cnt_d, wait_cnt_q;
  logic [HOLD_W-1:0]   hold_cnt_d, hold_cnt_q;
  logic                stall_d, stall_q;
  logic                grant_ok, stall_any;
  logic                ready_c, rden_c, wren_c, sel_c, merge_c, rd_push;
  logic                pipe_vld;
  logic [TAG_W-1:0]    pipe_tag;

  assign state_q  = state_t'(state_raw);
  assign grant_ok = ifc_dma_access_ok | stall_q;

  // Fetch is held off for the whole RMW and once a waiting request has starved
  assign stall_any = (state_q == RMW_RD) | (state_q == RMW_HOLD) | (state_q == RMW_WR) |
                     ((state_q == WAIT) & (wait_cnt_q == WCNT_MAX));

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    hold_cnt_d = '0;
    ready_c    = 1'b0;
    rden_c     = 1'b0;
    wren_c     = 1'b0;
    sel_c      = 1'b0;
    merge_c    = 1'b0;
    rd_push    = 1'b0;
    unique case (state_q)
      IDLE, WAIT: begin
        if (dma_iccm_req && grant_ok) begin
          ready_c = 1'b1;
          sel_c   = 1'b1;
          if (!dma_iccm_write) begin
            rden_c  = 1'b1;
            rd_push = 1'b1;
            state_d = IDLE;
          end else if (dma_iccm_size == SZ_DW) begin
            wren_c  = 1'b1;
            state_d = IDLE;
          end else begin
            rden_c  = 1'b1;
            state_d = RMW_RD;
          end
        end else if (dma_iccm_req) begin
          state_d    = WAIT;
          wait_cnt_d = (wait_cnt_q == WCNT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RMW_RD:   state_d = (RD_LAT > 2) ? RMW_HOLD : RMW_WR;
      RMW_HOLD: begin
        hold_cnt_d = hold_cnt_q + 1'b1;
        if (hold_cnt_q == HOLD_LAST) state_d = RMW_WR;
      end
      RMW_WR: begin
        wren_c  = 1'b1;
        merge_c = 1'b1;
        sel_c   = 1'b1;
        state_d = IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end

  assign stall_d = stall_any & ~rst;

  rvdff #(.WIDTH(3))      state_ff (.clk(clk), .rst(rst), .din(state_d),    .dout(state_raw));
  rvdff #(.WIDTH(WCNT_W)) wait_ff  (.clk(clk), .rst(rst), .din(wait_cnt_d), .dout(wait_cnt_q));
  rvdff #(.WIDTH(HOLD_W)) hold_ff  (.clk(clk), .rst(rst), .din(hold_cnt_d), .dout(hold_cnt_q));
  rvdff #(.WIDTH(1))      stall_ff (.clk(clk), .rst(rst), .din(stall_d),    .dout(stall_q));

  ifu_iccm_rdpipe #(.RD_LAT(RD_LAT), .TAG_W(TAG_W)) u_rdpipe (
    .clk    (clk),
    .rst    (rst),
    .rd_vld (rd_push & ~rst),
    .rd_tag (dma_iccm_tag),
    .out_vld(pipe_vld),
    .out_tag(pipe_tag)
  );

  // Outputs are forced quiet while reset is held
  assign dma_iccm_ready     = ready_c   & ~rst;
  assign dma_iccm_stall_any = stall_any & ~rst;
  assign iccm_sel_dma       = sel_c     & ~rst;
  assign iccm_rden          = rden_c    & ~rst;
  assign iccm_wren          = wren_c    & ~rst;
  assign iccm_rmw_merge     = merge_c   & ~rst;
  assign iccm_dma_rvalid    = pipe_vld  & ~rst;
  assign iccm_dma_rtag      = pipe_tag  & {TAG_W{~rst}};

endmodule

// File: tb/tb_ifu_iccm_dma_arb.sv
// Self-checking bench: single-cycle vector table plus multi-cycle sequences; read data
// returns are checked against a scoreboard of expected (cycle, tag) pairs.
module tb_ifu_iccm_dma_arb;

  localparam int RD_LAT = 2;
  localparam int TAG_W  = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             ok, req, wr;
  logic [1:0]       sz;
  logic [TAG_W-1:0] tag;
  logic             ready, stall, sel, rden, wren, merge, rvalid;
  logic [TAG_W-1:0] rtag;
  logic [5:0]       outs;

  ifu_iccm_dma_arb #(.RD_LAT(RD_LAT), .MAX_WAIT(15), .TAG_W(TAG_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .ifc_dma_access_ok (ok),
    .dma_iccm_req      (req),
    .dma_iccm_write    (wr),
    .dma_iccm_size     (sz),
    .dma_iccm_tag      (tag),
    .dma_iccm_ready    (ready),
    .dma_iccm_stall_any(stall),
    .iccm_sel_dma      (sel),
    .iccm_rden         (rden),
    .iccm_wren         (wren),
    .iccm_rmw_merge    (merge),
    .iccm_dma_rvalid   (rvalid),
    .iccm_dma_rtag     (rtag)
  );

  always #5 clk = ~clk;

  // {ready, rden, wren, sel, stall, merge}
  assign outs = {ready, rden, wren, sel, stall, merge};

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int               due;
    logic [TAG_W-1:0] tag;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic             ok, req, wr;
    logic [1:0]       sz;
    logic [TAG_W-1:0] tag;
    logic [5:0]       exp;
  } vec_t;
  vec_t tbl[8];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void push_rd(input logic [TAG_W-1:0] t);
    sb.push_back('{due: cyc + RD_LAT, tag: t});
  endfunction

  // Read-return monitor
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      chk("rvalid_due", 32'(rvalid), 32'd1);
      chk("rtag", 32'(rtag), 32'(sb[0].tag));
      void'(sb.pop_front());
    end else begin
      chk("rvalid_idle", 32'(rvalid), 32'd0);
    end
    chk("rden_wren_excl", 32'(rden & wren), 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic o, input logic r, input logic w,
                       input logic [1:0] s, input logic [TAG_W-1:0] t);
    ok = o; req = r; wr = w; sz = s; tag = t;
  endtask

  int gi;

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2'd0, '0);
    tbl[0] = '{1'b1, 1'b1, 1'b0, 2'd3, 3'd5, 6'b110100};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 2'd0, 3'd2, 6'b110100};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 2'd3, 3'd1, 6'b101100};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 2'd1, 3'd0, 6'b110100};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 6'b000000};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 2'd0, 3'd4, 6'b000000};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 2'd2, 3'd7, 6'b110100};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 2'd1, 3'd6, 6'b110100};

    tick();
    @(negedge clk);
    chk("reset_outs", 32'(outs), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_outs", 32'(outs), 32'd0);
    chk("post_reset_rtag", 32'(rtag), 32'd0);
    tick();

    // Single-cycle vectors, each started from IDLE
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].ok, tbl[i].req, tbl[i].wr, tbl[i].sz, tbl[i].tag);
      @(negedge clk);
      chk($sformatf("vec%0d", i), 32'(outs), 32'(tbl[i].exp));
      if (tbl[i].req && !tbl[i].wr && tbl[i].exp[4]) push_rd(tbl[i].tag);
      tick();
      req = 1'b0;
      repeat (4) tick();
    end

    // ok toggles with no request: nothing moves, starvation counter stays clear
    for (int i = 0; i < 20; i++) begin
      drive(i[0], 1'b0, 1'b0, 2'd0, '0);
      @(negedge clk);
      chk("idle_toggle", 32'(outs), 32'd0);
      tick();
    end

    // Starvation: fetch holds the port; stall by cycle 16, grant on 16 or 17
    drive(1'b0, 1'b1, 1'b0, 2'd3, 3'd4);
    gi = 0;
    for (int i = 1; i <= 20 && gi == 0; i++) begin
      @(negedge clk);
      if (i < 16) chk("starve_pre", 32'({stall, ready}), 32'd0);
      if (i == 16) chk("starve_stall16", 32'(stall), 32'd1);
      if (ready) begin
        gi = i;
        chk("starve_grant_rden", 32'(rden), 32'd1);
        push_rd(3'd4);
      end
      tick();
      if (gi != 0) req = 1'b0;
    end
    req = 1'b0;
    chk("starve_grant_cycle", 32'(gi == 16 || gi == 17), 32'd1);
    @(negedge clk);
    chk("starve_stall_drop", 32'(stall), 32'd0);
    tick();
    ok = 1'b1;
    repeat (3) tick();

    // Byte write RMW, with a read request queued behind it
    drive(1'b1, 1'b1, 1'b1, 2'd0, 3'd1);
    @(negedge clk);
    chk("rmw_grant", 32'(outs), 32'b110100);
    tick();
    drive(1'b1, 1'b1, 1'b0, 2'd3, 3'd6);
    @(negedge clk);
    chk("rmw_rd", 32'(outs), 32'b000010);
    tick();
    @(negedge clk);
    chk("rmw_wr", 32'(outs), 32'b001111);
    tick();
    @(negedge clk);
    chk("rmw_next_grant", 32'(outs), 32'b110100);
    push_rd(3'd6);
    tick();
    req = 1'b0;
    repeat (4) tick();

    // Reset during RMW_RD: write abandoned
    drive(1'b1, 1'b1, 1'b1, 2'd0, 3'd2);
    @(negedge clk);
    chk("rst_rmw_grant", 32'(outs), 32'b110100);
    tick();
    req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rmw_idle", 32'(outs), 32'd0);
    tick();
    @(negedge clk);
    chk("rst_rmw_no_wren", 32'(outs), 32'd0);
    tick();

    // Reset while a read is in flight: its rvalid must never appear
    drive(1'b1, 1'b1, 1'b0, 2'd3, 3'd3);
    @(negedge clk);
    chk("rst_rd_grant", 32'(outs), 32'b110100);
    tick();
    req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (4) tick();

    // Back-to-back reads, tags 1..3
    for (int t = 1; t <= 3; t++) begin
      drive(1'b1, 1'b1, 1'b0, 2'd3, 3'(t));
      @(negedge clk);
      chk("b2b_grant", 32'(outs), 32'b110100);
      push_rd(3'(t));
      tick();
    end
    req = 1'b0;
    repeat (6) tick();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
